// File: rtl/seg_scan_driver_if.sv
// Bus bundle for seg_scan_driver: display load/data in, segment and digit-select drive out.
// The slave modport is the driver side; the master modport belongs to whoever loads the display.
interface seg_scan_driver_if;
    logic        load;
    logic [31:0] data;
    logic [7:0]  seg0;
    logic [7:0]  seg1;
    logic [3:0]  sel0;
    logic [3:0]  sel1;

    modport master (
        output load, data,
        input  seg0, seg1, sel0, sel1
    );

    modport slave (
        input  load, data,
        output seg0, seg1, sel0, sel1
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Two-bank 8-digit hex seven-segment scanner; both banks scan in lockstep with a blank cycle per digit.
// Optional leading-zero blanking is built when SEG_LEADING_ZERO_BLANK_EN is defined.
module seg_scan_driver #(
    parameter int unsigned DWELL = 4
) (
    input  logic              clk_slow,
    input  logic              rst,
    seg_scan_driver_if.slave  bus
);
    localparam logic [7:0] DW_LAST = 8'(DWELL - 1);

    logic [31:0] disp_q, disp_d;
    logic [1:0]  idx_q,  idx_d;
    logic [7:0]  dw_q,   dw_d;
    logic [7:0]  seg0_q, seg0_d;
    logic [7:0]  seg1_q, seg1_d;
    logic [3:0]  sel0_q, sel0_d;
    logic [3:0]  sel1_q, sel1_d;
    logic [3:0]  nib_lo, nib_hi;

    function automatic logic [7:0] hex_seg(input logic [3:0] n);
        logic [7:0] s;
        case (n)
            4'h0:    s = 8'h3F;
            4'h1:    s = 8'h06;
            4'h2:    s = 8'h5B;
            4'h3:    s = 8'h4F;
            4'h4:    s = 8'h66;
            4'h5:    s = 8'h6D;
            4'h6:    s = 8'h7D;
            4'h7:    s = 8'h07;
            4'h8:    s = 8'h7F;
            4'h9:    s = 8'h6F;
            4'hA:    s = 8'h77;
            4'hB:    s = 8'h7C;
            4'hC:    s = 8'h39;
            4'hD:    s = 8'h5E;
            4'hE:    s = 8'h79;
            default: s = 8'h71;
        endcase
        return s;
    endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Position of the most significant non-zero nibble; 0 when the value is zero so digit 0 stays lit.
    function automatic logic [2:0] top_digit(input logic [31:0] v);
        logic [2:0] t;
        t = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (v[4*k +: 4] != 4'h0) t = 3'(k);
        end
        return t;
    endfunction

    logic [2:0] top;
    assign top = top_digit(disp_q);
`endif

    assign nib_lo = disp_q[{1'b0, idx_q, 2'b00} +: 4];
    assign nib_hi = disp_q[{1'b1, idx_q, 2'b00} +: 4];

    always_comb begin
        disp_d = bus.load ? bus.data : disp_q;
        dw_d   = dw_q + 8'd1;
        idx_d  = idx_q;
        if (dw_q == DW_LAST) begin
            dw_d  = 8'd0;
            idx_d = idx_q + 2'd1;
        end

        seg0_d = 8'h00;
        seg1_d = 8'h00;
        sel0_d = 4'b0000;
        sel1_d = 4'b0000;
        // dw==0 is the blanking slot between digits that keeps the previous digit from ghosting.
        if (dw_q != 8'd0) begin
            sel0_d = 4'b0001 << idx_q;
            sel1_d = 4'b0001 << idx_q;
            seg0_d = hex_seg(nib_lo);
            seg1_d = hex_seg(nib_hi);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            if ({1'b0, idx_q} > top) seg0_d = 8'h00;
            if ({1'b1, idx_q} > top) seg1_d = 8'h00;
`endif
        end
    end

    always_ff @(posedge clk_slow) begin
        if (!rst) begin
            disp_q <= '0;
            idx_q  <= '0;
            dw_q   <= '0;
            seg0_q <= '0;
            seg1_q <= '0;
            sel0_q <= '0;
            sel1_q <= '0;
        end else begin
            disp_q <= disp_d;
            idx_q  <= idx_d;
            dw_q   <= dw_d;
            seg0_q <= seg0_d;
            seg1_q <= seg1_d;
            sel0_q <= sel0_d;
            sel1_q <= sel1_d;
        end
    end

    assign bus.seg0 = seg0_q;
    assign bus.seg1 = seg1_q;
    assign bus.sel0 = sel0_q;
    assign bus.sel1 = sel1_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: arithmetic scan model checked every cycle plus hand-computed spot checks.
// Honors SEG_LEADING_ZERO_BLANK_EN the same way the design does.
module tb_seg_scan_driver;
    localparam int DWELL = 4;
    localparam logic [7:0] HEX [0:15] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                          8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ = 8'h00;
`else
    localparam logic [7:0] LZ = 8'h3F;
`endif

    logic clk_slow = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    seg_scan_driver_if bus ();

    seg_scan_driver #(.DWELL(DWELL)) dut (
        .clk_slow (clk_slow),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk_slow = ~clk_slow;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step_n(input int n);
        repeat (n) begin
            @(posedge clk_slow);
            @(negedge clk_slow);
        end
    endtask

    task automatic chk_all(input string tag, input logic [3:0] sel,
                           input logic [7:0] s0, input logic [7:0] s1);
        chk({tag, ".sel0"}, 8'(bus.sel0), 8'(sel));
        chk({tag, ".sel1"}, 8'(bus.sel1), 8'(sel));
        chk({tag, ".seg0"}, bus.seg0, s0);
        chk({tag, ".seg1"}, bus.seg1, s1);
    endtask

    // Digit k of d as the display must show it.
    function automatic logic [7:0] model_seg(input logic [31:0] d, input int k);
        int nib;
`ifdef SEG_LEADING_ZERO_BLANK_EN
        int top;
        top = 0;
        for (int j = 0; j < 8; j++)
            if (((d >> (4 * j)) & 32'hF) != 32'h0) top = j;
        if (k > top) return 8'h00;
`endif
        nib = int'((d >> (4 * k)) & 32'hF);
        return HEX[nib];
    endfunction

    // Model: mp counts edges since reset release modulo one refresh period.
    logic        mvalid = 1'b0;
    int          mp;
    logic [31:0] mdisp;
    logic [7:0]  e_seg0, e_seg1;
    logic [3:0]  e_sel;

    always @(posedge clk_slow) begin
        if (!rst) begin
            mvalid <= 1'b1;
            mp     <= 0;
            mdisp  <= '0;
            e_sel  <= '0;
            e_seg0 <= '0;
            e_seg1 <= '0;
        end else begin
            if (mp % DWELL == 0) begin
                e_sel  <= '0;
                e_seg0 <= '0;
                e_seg1 <= '0;
            end else begin
                e_sel  <= 4'(1 << ((mp / DWELL) % 4));
                e_seg0 <= model_seg(mdisp, (mp / DWELL) % 4);
                e_seg1 <= model_seg(mdisp, (mp / DWELL) % 4 + 4);
            end
            if (bus.load) mdisp <= bus.data;
            mp <= (mp + 1) % (4 * DWELL);
        end
    end

    always @(negedge clk_slow) begin
        if (mvalid) chk_all("model", e_sel, e_seg0, e_seg1);
    end

    initial begin
        rst      = 1'b0;
        bus.load = 1'b0;
        bus.data = '0;
        step_n(2);
        chk_all("reset", 4'b0000, 8'h00, 8'h00);

        // Release: edge 1 dead, 2-4 digit 0, 5 dead, 6-8 digit 1.
        rst = 1'b1;
        step_n(1);
        chk_all("rel_e1", 4'b0000, 8'h00, 8'h00);
        for (int k = 2; k <= 4; k++) begin
            step_n(1);
            chk_all("rel_d0", 4'b0001, 8'h3F, LZ);
        end
        step_n(1);
        chk_all("rel_e5", 4'b0000, 8'h00, 8'h00);
        for (int k = 6; k <= 8; k++) begin
            step_n(1);
            chk_all("rel_d1", 4'b0010, LZ, LZ);
        end

        // Capture 1234ABCD at edge 9; edge 14 is idx3 lit, edge 18 idx0 lit.
        bus.load = 1'b1;
        bus.data = 32'h1234ABCD;
        step_n(1);
        bus.load = 1'b0;
        bus.data = 32'h0;
        step_n(5);
        chk_all("abcd_i3", 4'b1000, 8'h77, 8'h06);
        step_n(4);
        chk_all("abcd_i0", 4'b0001, 8'h5E, 8'h66);

        // Capture DEADBEEF at edge 19, then 64 cycles of toggling data with load low.
        bus.load = 1'b1;
        bus.data = 32'hDEADBEEF;
        step_n(1);
        bus.load = 1'b0;
        repeat (64) begin
            bus.data = $urandom;
            step_n(1);
        end
        chk_all("hold_e83", 4'b0001, 8'h71, 8'h5E);

        // Reset at the edge whose pre-edge state is idx2 dw2 (edge 91).
        step_n(7);
        rst = 1'b0;
        step_n(1);
        chk_all("midrst", 4'b0000, 8'h00, 8'h00);
        rst = 1'b1;
        step_n(1);
        chk_all("midrst_dead", 4'b0000, 8'h00, 8'h00);
        step_n(1);
        chk_all("midrst_d0", 4'b0001, 8'h3F, LZ);

        // Load with reset low: reset wins, display stays zero.
        rst      = 1'b0;
        bus.load = 1'b1;
        bus.data = 32'hFFFFFFFF;
        step_n(1);
        rst      = 1'b1;
        bus.load = 1'b0;
        step_n(1);
        chk_all("rstwin_dead", 4'b0000, 8'h00, 8'h00);
        step_n(1);
        chk_all("rstwin_d0", 4'b0001, 8'h3F, LZ);

        // 000000A0: digit0 "0", digit1 "A", everything above blank or "0".
        bus.load = 1'b1;
        bus.data = 32'h0000_00A0;
        step_n(1);
        bus.load = 1'b0;
        step_n(1);
        chk_all("a0_d0", 4'b0001, 8'h3F, LZ);
        step_n(2);
        chk_all("a0_d1", 4'b0010, 8'h77, LZ);
        step_n(4);
        chk_all("a0_d2", 4'b0100, LZ, LZ);
        step_n(4);
        chk_all("a0_d3", 4'b1000, LZ, LZ);

        // Mixed traffic with sparse loads and one more mid-scan reset, checked by the model.
        for (int i = 0; i < 200; i++) begin
            bus.load = ($urandom_range(0, 3) == 0);
            bus.data = (i % 3 == 0) ? ($urandom >> ($urandom_range(0, 7) * 4)) : $urandom;
            rst      = (i != 100);
            step_n(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
